// File: rtl/prescaled_mod_counter_if.sv
// Control/status bundle for prescaled_mod_counter: the master drives the
// control fields, the counter (slave) returns count, tc and running.
interface prescaled_mod_counter_if #(
  parameter int WIDTH = 8,
  parameter int PSC_W = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] modulus;
  logic [PSC_W-1:0] prescale;
  logic [1:0]       mode;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             running;

  modport master (
    output en, up, load, load_val, modulus, prescale, mode,
    input  count, tc, running
  );

  modport slave (
    input  en, up, load, load_val, modulus, prescale, mode,
    output count, tc, running
  );
endinterface

// File: rtl/prescaled_mod_counter.sv
// Up/down modulo counter advanced by a programmable prescaler, with wrap,
// saturate and one-shot terminal actions, a load strobe and a tc pulse.
module prescaled_mod_counter #(
  parameter int WIDTH = 8,
  parameter int PSC_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  prescaled_mod_counter_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_SATURATE = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_WRAP_ALT = 2'b11
  } mode_e;

  logic [PSC_W-1:0] psc_cnt;
  logic             tick;
  logic             terminal;
  mode_e            mode;

  assign mode = mode_e'(bus.mode);

  // Prescaler compares for equality only: a count left above a newly lowered
  // prescale must roll through zero before it can tick again.
  assign tick = bus.en && (psc_cnt == bus.prescale) && bus.running;

  // A count above modulus is terminal going up, but still counts down normally.
  assign terminal = bus.up ? (bus.count >= bus.modulus) : (bus.count == '0);

  // NOTE: all state here is registered, so every assignment is non-blocking;
  // reset is sampled on the clock edge and outranks load and tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.count   <= '0;
      psc_cnt     <= '0;
      bus.tc      <= 1'b0;
      bus.running <= 1'b1;
    end else if (bus.load) begin
      bus.count   <= bus.load_val;
      psc_cnt     <= '0;
      bus.tc      <= 1'b0;
      bus.running <= 1'b1;
    end else begin
      bus.tc <= 1'b0;
      if (bus.running && bus.en) begin
        if (tick) begin
          psc_cnt <= '0;
          if (terminal) begin
            bus.tc <= 1'b1;
            case (mode)
              MODE_SATURATE: bus.count <= bus.count;
              MODE_ONESHOT:  bus.running <= 1'b0;
              default:       bus.count <= bus.up ? '0 : bus.modulus;
            endcase
          end else begin
            bus.count <= bus.up ? bus.count + WIDTH'(1) : bus.count - WIDTH'(1);
          end
        end else begin
          psc_cnt <= psc_cnt + PSC_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_prescaled_mod_counter.sv
// Directed bench for prescaled_mod_counter: stimulus pushes the expected
// post-edge state into a scoreboard queue, a monitor pops and compares.
module tb_prescaled_mod_counter;

  localparam int WIDTH = 8;
  localparam int PSC_W = 4;

  typedef struct {
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             running;
    string            name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];

  prescaled_mod_counter_if #(.WIDTH(WIDTH), .PSC_W(PSC_W)) bus ();

  prescaled_mod_counter #(.WIDTH(WIDTH), .PSC_W(PSC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs are changed on the falling edge; the expected state after the
  // following rising edge is queued before that edge arrives.
  task automatic step(input string name, input logic [WIDTH-1:0] c, input logic t, input logic r);
    exp_t e;
    e.count = c; e.tc = t; e.running = r; e.name = name;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: one observation per rising edge, sampled 1 time unit after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check({e.name, ".count"},   32'(bus.count),   32'(e.count));
        check({e.name, ".tc"},      32'(bus.tc),      32'(e.tc));
        check({e.name, ".running"}, 32'(bus.running), 32'(e.running));
      end
    end
  end

  logic [WIDTH-1:0] wrap_seq [12] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd0, 8'd1, 8'd2};

  initial begin
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.up       = 1'b1;
    bus.load     = 1'b1;
    bus.load_val = 8'h33;
    bus.modulus  = 8'd9;
    bus.prescale = '0;
    bus.mode     = 2'b00;
    @(negedge clk);

    // Reset outranks a simultaneous load.
    step("reset_over_load", 8'd0, 1'b0, 1'b1);
    bus.load = 1'b0;
    step("reset_hold", 8'd0, 1'b0, 1'b1);

    // Wrap up to modulus 9, one tick per cycle.
    rst_n  = 1'b1;
    bus.en = 1'b1;
    for (int i = 0; i < 12; i++)
      step($sformatf("wrap_up_%0d", i), wrap_seq[i], (i == 9), 1'b1);

    // Prescale 3: one tick every 4 enabled cycles; en gap delays the tick.
    bus.prescale = 4'd3;
    bus.load = 1'b1; bus.load_val = 8'd0;
    step("psc_load", 8'd0, 1'b0, 1'b1);
    bus.load = 1'b0;
    step("psc_a0", 8'd0, 1'b0, 1'b1);
    step("psc_a1", 8'd0, 1'b0, 1'b1);
    step("psc_a2", 8'd0, 1'b0, 1'b1);
    step("psc_a_tick", 8'd1, 1'b0, 1'b1);
    step("psc_b0", 8'd1, 1'b0, 1'b1);
    step("psc_b1", 8'd1, 1'b0, 1'b1);
    bus.en = 1'b0;
    step("psc_gap0", 8'd1, 1'b0, 1'b1);
    step("psc_gap1", 8'd1, 1'b0, 1'b1);
    bus.en = 1'b1;
    step("psc_b2", 8'd1, 1'b0, 1'b1);
    step("psc_b_tick", 8'd2, 1'b0, 1'b1);

    // Saturate counting down from 2.
    bus.prescale = '0; bus.mode = 2'b01; bus.up = 1'b0;
    bus.load = 1'b1; bus.load_val = 8'd2;
    step("sat_load", 8'd2, 1'b0, 1'b1);
    bus.load = 1'b0;
    step("sat_1", 8'd1, 1'b0, 1'b1);
    step("sat_0", 8'd0, 1'b0, 1'b1);
    step("sat_hold0", 8'd0, 1'b1, 1'b1);
    step("sat_hold1", 8'd0, 1'b1, 1'b1);

    // One-shot to modulus 3, then frozen until a load.
    bus.mode = 2'b10; bus.up = 1'b1; bus.modulus = 8'd3;
    bus.load = 1'b1; bus.load_val = 8'd0;
    step("os_load", 8'd0, 1'b0, 1'b1);
    bus.load = 1'b0;
    step("os_1", 8'd1, 1'b0, 1'b1);
    step("os_2", 8'd2, 1'b0, 1'b1);
    step("os_3", 8'd3, 1'b0, 1'b1);
    step("os_term", 8'd3, 1'b1, 1'b0);
    step("os_stopped", 8'd3, 1'b0, 1'b0);
    bus.mode = 2'b00;
    step("os_stopped_mode", 8'd3, 1'b0, 1'b0);
    bus.load = 1'b1; bus.load_val = 8'd0;
    step("os_reload", 8'd0, 1'b0, 1'b1);
    bus.load = 1'b0;
    step("os_restart", 8'd1, 1'b0, 1'b1);

    // Load wins over a coincident tick; load above modulus is terminal going up.
    bus.modulus = 8'd9;
    bus.load = 1'b1; bus.load_val = 8'h55;
    step("load_over_tick", 8'h55, 1'b0, 1'b1);
    bus.load = 1'b0;
    step("above_mod_wrap", 8'd0, 1'b1, 1'b1);
    rst_n = 1'b0; bus.load = 1'b1;
    step("reset_with_load", 8'd0, 1'b0, 1'b1);
    rst_n = 1'b1; bus.load = 1'b0;

    // Modulus 5 with a loaded 200: wrap up, plain decrement down.
    bus.modulus = 8'd5;
    bus.load = 1'b1; bus.load_val = 8'd200;
    step("big_load_up", 8'd200, 1'b0, 1'b1);
    bus.load = 1'b0;
    step("big_up_wrap", 8'd0, 1'b1, 1'b1);
    bus.up = 1'b0; bus.load = 1'b1;
    step("big_load_dn", 8'd200, 1'b0, 1'b1);
    bus.load = 1'b0;
    step("big_dn", 8'd199, 1'b0, 1'b1);

    // Wrap down through zero reloads modulus.
    bus.load = 1'b1; bus.load_val = 8'd1;
    step("wdn_load", 8'd1, 1'b0, 1'b1);
    bus.load = 1'b0;
    step("wdn_0", 8'd0, 1'b0, 1'b1);
    step("wdn_wrap", 8'd5, 1'b1, 1'b1);
    step("wdn_4", 8'd4, 1'b0, 1'b1);

    // Modulus 0 counting up: tc on every tick.
    bus.up = 1'b1; bus.modulus = 8'd0;
    bus.load = 1'b1; bus.load_val = 8'd0;
    step("mod0_load", 8'd0, 1'b0, 1'b1);
    bus.load = 1'b0;
    for (int i = 0; i < 3; i++)
      step($sformatf("mod0_%0d", i), 8'd0, 1'b1, 1'b1);

    // Prescale lowered below the running prescaler: roll through 15 first.
    bus.modulus = 8'd5; bus.prescale = 4'd7;
    bus.load = 1'b1; bus.load_val = 8'd0;
    step("pchg_load", 8'd0, 1'b0, 1'b1);
    bus.load = 1'b0;
    for (int i = 0; i < 5; i++)
      step($sformatf("pchg_pre_%0d", i), 8'd0, 1'b0, 1'b1);
    bus.prescale = 4'd2;
    for (int i = 0; i < 13; i++)
      step($sformatf("pchg_roll_%0d", i), 8'd0, 1'b0, 1'b1);
    step("pchg_tick", 8'd1, 1'b0, 1'b1);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() > 0) begin
      failures++;
      checks++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
